// File: rtl/hsync_framer.sv
// Horizontal sync framer: finds sync pulses in filtered luma, skips the back porch and
// emits ACTIVE_LEN saturated 8-bit pixels per line with tlast on the final pixel.
module hsync_framer #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 8,
  parameter int SYNC_THRESH            = -1000,
  parameter int SYNC_MIN_LEN           = 64,
  parameter int BLANK_LEN              = 120,
  parameter int ACTIVE_LEN             = 640,
  parameter int SHIFT                  = 8
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_aresetn,
  input  logic                                  s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
  input  logic                                  s00_axis_tlast,
  output logic                                  s00_axis_tready,
  input  logic                                  m00_axis_tready,
  output logic                                  m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
  output logic                                  m00_axis_tlast,
  output logic [15:0]                           line_count,
  output logic [7:0]                            trunc_count
);

  localparam int IW      = C_S00_AXIS_TDATA_WIDTH;
  localparam int OW      = C_M00_AXIS_TDATA_WIDTH;
  localparam int MAX_AB  = (SYNC_MIN_LEN > BLANK_LEN) ? SYNC_MIN_LEN : BLANK_LEN;
  localparam int MAX_LEN = (MAX_AB > ACTIVE_LEN) ? MAX_AB : ACTIVE_LEN;
  localparam int CW      = $clog2(MAX_LEN + 1);

  localparam logic signed [IW-1:0] THRESH  = IW'(SYNC_THRESH);
  localparam logic signed [IW-1:0] PIX_MAX = IW'((1 << OW) - 1);
  localparam logic [CW-1:0] SYNC_END   = CW'(SYNC_MIN_LEN);
  localparam logic [CW-1:0] BLANK_END  = CW'(BLANK_LEN);
  localparam logic [CW-1:0] ACTIVE_END = CW'(ACTIVE_LEN - 1);

  typedef enum logic [1:0] {SEARCH, SYNC, BACKPORCH, ACTIVE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;
  logic            out_vld_q, out_vld_d;
  logic [OW-1:0]   out_dat_q, out_dat_d;
  logic            out_last_q, out_last_d;
  logic [15:0]     line_q, line_d;
  logic [7:0]      trunc_q, trunc_d;

  logic signed [IW-1:0] sample;
  logic signed [IW-1:0] shifted;
  logic [OW-1:0]        pixel;
  logic                 sync_lvl;
  logic                 accept;
  logic                 line_end;
  logic                 unused_tstrb;

  assign unused_tstrb = ^s00_axis_tstrb;

  // Single output register: upstream may only advance when that register can be freed.
  assign s00_axis_tready = ~out_vld_q | m00_axis_tready;
  assign accept          = s00_axis_tvalid & s00_axis_tready;

  assign sample   = $signed(s00_axis_tdata);
  assign shifted  = sample >>> SHIFT;
  assign sync_lvl = sample < THRESH;
  assign cnt_inc  = cnt_q + CW'(1);
  assign line_end = (cnt_q == ACTIVE_END);

  always_comb begin
    pixel = shifted[OW-1:0];
    if (shifted < 0) begin
      pixel = '0;
    end else if (shifted > PIX_MAX) begin
      pixel = '1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    trunc_d    = trunc_q;
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    out_last_d = out_last_q;

    if (m00_axis_tready) begin
      out_vld_d  = 1'b0;
      out_last_d = 1'b0;
    end

    if (accept) begin
      case (state_q)
        SEARCH: begin
          if (!sync_lvl) begin
            cnt_d = '0;
          end else if (cnt_inc == SYNC_END) begin
            state_d = SYNC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        SYNC: begin
          // The first non-sync sample already counts as back-porch sample 1.
          if (!sync_lvl) begin
            if (BLANK_LEN == 1) begin
              state_d = ACTIVE;
              cnt_d   = '0;
            end else begin
              state_d = BACKPORCH;
              cnt_d   = CW'(1);
            end
          end
        end
        BACKPORCH: begin
          if (cnt_inc == BLANK_END) begin
            state_d = ACTIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ACTIVE: begin
          out_vld_d  = 1'b1;
          out_dat_d  = pixel;
          out_last_d = line_end | s00_axis_tlast;
          if (line_end || s00_axis_tlast) begin
            state_d = SEARCH;
            cnt_d   = '0;
            line_d  = line_q + 16'd1;
            if (!line_end && trunc_q != 8'hFF) begin
              trunc_d = trunc_q + 8'd1;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = SEARCH;
          cnt_d   = '0;
        end
      endcase

      if (s00_axis_tlast) begin
        state_d = SEARCH;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q    <= SEARCH;
      cnt_q      <= '0;
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      out_last_q <= 1'b0;
      line_q     <= '0;
      trunc_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      out_last_q <= out_last_d;
      line_q     <= line_d;
      trunc_q    <= trunc_d;
    end
  end

  assign m00_axis_tvalid = out_vld_q;
  assign m00_axis_tdata  = out_dat_q;
  assign m00_axis_tlast  = out_last_q;
  assign m00_axis_tstrb  = '1;
  assign line_count      = line_q;
  assign trunc_count     = trunc_q;

endmodule

// File: tb/tb_hsync_framer.sv
// Directed bench for hsync_framer with short sync/porch/line lengths.
module tb_hsync_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        s_vld = 1'b0;
  logic [31:0] s_dat = '0;
  logic [3:0]  s_strb = 4'hF;
  logic        s_last = 1'b0;
  logic        s_rdy;
  logic        m_rdy = 1'b1;
  logic        m_vld;
  logic [7:0]  m_dat;
  logic [0:0]  m_strb;
  logic        m_last;
  logic [15:0] line_cnt;
  logic [7:0]  trunc_cnt;

  int checks = 0;
  int errors = 0;
  logic [8:0] got_q[$];
  logic       bp_mode = 1'b0;
  logic       prev_hold = 1'b0;
  logic [8:0] prev_beat = '0;
  logic [3:0] rdy_pat = 4'b1001;
  int         ph = 0;

  always #5 clk = ~clk;

  hsync_framer #(
    .C_S00_AXIS_TDATA_WIDTH(32),
    .C_M00_AXIS_TDATA_WIDTH(8),
    .SYNC_THRESH(-1000),
    .SYNC_MIN_LEN(4),
    .BLANK_LEN(3),
    .ACTIVE_LEN(8),
    .SHIFT(8)
  ) dut (
    .s00_axis_aclk(clk),
    .s00_axis_aresetn(rst_n),
    .s00_axis_tvalid(s_vld),
    .s00_axis_tdata(s_dat),
    .s00_axis_tstrb(s_strb),
    .s00_axis_tlast(s_last),
    .s00_axis_tready(s_rdy),
    .m00_axis_tready(m_rdy),
    .m00_axis_tvalid(m_vld),
    .m00_axis_tdata(m_dat),
    .m00_axis_tstrb(m_strb),
    .m00_axis_tlast(m_last),
    .line_count(line_cnt),
    .trunc_count(trunc_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Beat collector plus stall-stability checks, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (bp_mode) begin
        chk("s_rdy_comb", {31'd0, s_rdy}, {31'd0, (~m_vld | m_rdy)});
        if (prev_hold) chk("stall_hold", {22'd0, m_vld, m_last, m_dat}, {22'd0, 1'b1, prev_beat});
      end
      prev_hold = m_vld & ~m_rdy;
      prev_beat = {m_last, m_dat};
      if (m_vld && m_rdy) got_q.push_back({m_last, m_dat});
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (bp_mode) begin
      m_rdy = rdy_pat[3 - ph];
      ph = (ph + 1) % 4;
    end
  end

  task automatic send(input logic [31:0] d, input logic l);
    int g = 0;
    s_vld  = 1'b1;
    s_dat  = d;
    s_last = l;
    while (!s_rdy && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) chk("send_timeout", {31'd0, s_rdy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    s_vld  = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic preamble();
    repeat (4) send(-32'sd2000, 1'b0);
    repeat (3) begin
      send(32'd0, 1'b0);
      chk("porch_quiet", {31'd0, m_vld}, 32'd0);
    end
  endtask

  task automatic send_px(input string tag, input logic [31:0] d, input logic l,
                         input logic [7:0] px, input logic lst);
    send(d, l);
    chk({tag, "_vld"}, {31'd0, m_vld}, 32'd1);
    chk({tag, "_dat"}, {24'd0, m_dat}, {24'd0, px});
    chk({tag, "_last"}, {31'd0, m_last}, {31'd0, lst});
  endtask

  task automatic full_line(input string tag);
    preamble();
    for (int k = 0; k < 8; k++) send_px(tag, 32'(256 * k), 1'b0, 8'(k), k == 7);
  endtask

  task automatic wait_beats(input int n);
    int g = 0;
    while (got_q.size() < n && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (got_q.size() < n) chk("drain_timeout", got_q.size(), n);
  endtask

  logic [31:0] sat_in [8];
  logic [7:0]  sat_px [8];

  initial begin
    sat_in = '{32'hFFFF_EC78, 32'h0000_FF7F, 32'h0002_0000, 32'd255,
               32'd1024, 32'd1280, 32'd1536, 32'd1792};
    sat_px = '{8'd0, 8'd255, 8'd255, 8'd0, 8'd4, 8'd5, 8'd6, 8'd7};

    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_vld", {31'd0, m_vld}, 32'd0);
    chk("rst_last", {31'd0, m_last}, 32'd0);
    chk("rst_dat", {24'd0, m_dat}, 32'd0);
    chk("rst_strb", {31'd0, m_strb}, 32'd1);
    chk("rst_line", {16'd0, line_cnt}, 32'd0);
    chk("rst_trunc", {24'd0, trunc_cnt}, 32'd0);
    chk("rst_rdy", {31'd0, s_rdy}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    got_q.delete();
    full_line("basic");
    @(negedge clk);
    chk("basic_idle", {31'd0, m_vld}, 32'd0);
    chk("basic_line", {16'd0, line_cnt}, 32'd1);
    chk("basic_beats", got_q.size(), 32'd8);

    got_q.delete();
    repeat (3) send(-32'sd2000, 1'b0);
    send(32'd0, 1'b0);
    repeat (20) send(32'h0001_0000, 1'b0);
    repeat (2) @(negedge clk);
    chk("short_beats", got_q.size(), 32'd0);
    chk("short_line", {16'd0, line_cnt}, 32'd1);

    preamble();
    for (int k = 0; k < 8; k++) send_px("sat", sat_in[k], 1'b0, sat_px[k], k == 7);
    chk("sat_line", {16'd0, line_cnt}, 32'd2);

    repeat (2) @(negedge clk);
    got_q.delete();
    preamble();
    bp_mode = 1'b1;
    for (int k = 0; k < 8; k++) send(32'(256 * k), 1'b0);
    wait_beats(8);
    @(negedge clk);
    bp_mode = 1'b0;
    m_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp_beats", got_q.size(), 32'd8);
    for (int k = 0; k < 8 && k < got_q.size(); k++)
      chk("bp_beat", {23'd0, got_q[k]}, {23'd0, (k == 7), 8'(k)});
    chk("bp_line", {16'd0, line_cnt}, 32'd3);

    got_q.delete();
    preamble();
    for (int k = 0; k < 5; k++) send_px("trunc", 32'(256 * k), k == 4, 8'(k), k == 4);
    repeat (2) @(negedge clk);
    chk("trunc_beats", got_q.size(), 32'd5);
    chk("trunc_line", {16'd0, line_cnt}, 32'd4);
    chk("trunc_cnt", {24'd0, trunc_cnt}, 32'd1);
    full_line("after_trunc");
    chk("after_trunc_line", {16'd0, line_cnt}, 32'd5);
    chk("after_trunc_cnt", {24'd0, trunc_cnt}, 32'd1);

    preamble();
    for (int k = 0; k < 3; k++) send_px("pre_rst", 32'(256 * k), 1'b0, 8'(k), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_vld", {31'd0, m_vld}, 32'd0);
    chk("midrst_last", {31'd0, m_last}, 32'd0);
    chk("midrst_line", {16'd0, line_cnt}, 32'd0);
    chk("midrst_trunc", {24'd0, trunc_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    full_line("post_rst");
    chk("post_rst_line", {16'd0, line_cnt}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
